mips_multicycle_core: RTL and testbench

Parametrised multi-cycle successor to the single-cycle MIPS core: the same MIPS subset, run by a control FSM in 3–5 cycles per instruction. A single unified, word-addressed memory port with a request/ready handshake replaces the separate instruction and data memories, so the core tolerates wait states. It sits at the top of the processor, between an external memory model or bus adapter and the debug/trace logic.

---
 rtl/mips_pkg.sv | 77 +++++++
 rtl/mips_multicycle_core_if.sv | 20 ++
 rtl/mips_mc_regfile.sv | 29 ++
 rtl/mips_multicycle_core.sv | 156 +++++++++++++++
 tb/tb_mips_multicycle_core.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the multi-cycle MIPS core.
//   - opcode and funct encodings of the supported MIPS subset
//   - ALU operation encoding
//   - control FSM state encoding
//   - instruction class and the helpers that decode it from opcode/funct
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL
    } alu_op_t;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB, HALT
    } state_t;

    typedef enum logic [3:0] {
        I_ALU_R, I_JR, I_ADDI, I_LW, I_SW, I_BEQ, I_BNE, I_J, I_JAL, I_ILLEGAL
    } iclass_t;

    // Anything not explicitly listed, including unknown R-type functs, is illegal.
    function automatic iclass_t decode_class(input logic [5:0] opcode, input logic [5:0] funct);
        iclass_t c;
        c = I_ILLEGAL;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR,
                    FN_SLT, FN_SLL, FN_SRL: c = I_ALU_R;
                    FN_JR:                  c = I_JR;
                    default:                c = I_ILLEGAL;
                endcase
            end
            OP_ADDI: c = I_ADDI;
            OP_LW:   c = I_LW;
            OP_SW:   c = I_SW;
            OP_BEQ:  c = I_BEQ;
            OP_BNE:  c = I_BNE;
            OP_J:    c = I_J;
            OP_JAL:  c = I_JAL;
            default: c = I_ILLEGAL;
        endcase
        return c;
    endfunction

    function automatic alu_op_t alu_op_for(input logic [5:0] funct);
        alu_op_t op;
        case (funct)
            FN_SUB:  op = ALU_SUB;
            FN_AND:  op = ALU_AND;
            FN_OR:   op = ALU_OR;
            FN_SLT:  op = ALU_SLT;
            FN_SLL:  op = ALU_SLL;
            FN_SRL:  op = ALU_SRL;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mips_multicycle_core_if.sv
// mips_multicycle_core_if: unified word-addressed memory port.
//   mem_req   core -> mem : request, held until mem_ready
//   mem_we    core -> mem : 1 = write (sw), 0 = read
//   mem_addr  core -> mem : word address
//   mem_wdata core -> mem : store data
//   mem_rdata mem -> core : read data, valid in the mem_ready cycle
//   mem_ready mem -> core : request accepted/completed this cycle
interface mips_multicycle_core_if #(parameter int ADDR_W = 16);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                    input  mem_rdata, mem_ready);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                    output mem_rdata, mem_ready);
endinterface

// File: rtl/mips_mc_regfile.sv
// mips_mc_regfile: 32 x 32 register file.
//   clock, reset     : clock and synchronous active-high clear of all registers
//   rs_addr/rs_data  : asynchronous read port A
//   rt_addr/rt_data  : asynchronous read port B
//   we/wr_addr/wr_data : synchronous write port; writes to r0 are dropped
module mips_mc_regfile (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    input  logic        we,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);
    logic [31:0] regs [32];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && wr_addr != 5'd0) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rs_data = (rs_addr == 5'd0) ? '0 : regs[rs_addr];
    assign rt_data = (rt_addr == 5'd0) ? '0 : regs[rt_addr];
endmodule

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multi-cycle MIPS subset core (3-5 cycles per instruction).
//   clock, reset : clock and synchronous active-high reset
//   mem          : unified memory port (master side, request/ready handshake)
//   pc           : address of the instruction currently executing
//   halted       : core stopped on an unsupported instruction (left only by reset)
module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                          clock,
    input  logic                          reset,
    mips_multicycle_core_if.master        mem,
    output logic [ADDR_W-1:0]             pc,
    output logic                          halted
);
    state_t            state;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       ir, a_q, b_q, alu_out, mdr;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm_sext, rs_data, rt_data, alu_b, alu_result, rf_wdata;
    iclass_t     iclass;
    alu_op_t     alu_op;
    logic        taken, rf_we;
    logic [4:0]  rf_waddr;
    logic [ADDR_W-1:0] pc_plus1, branch_target, jump_target;

    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign shamt    = ir[10:6];
    assign funct    = ir[5:0];
    assign imm_sext = {{16{ir[15]}}, ir[15:0]};
    assign iclass   = decode_class(opcode, funct);
    assign alu_op   = (iclass == I_ALU_R) ? alu_op_for(funct) : ALU_ADD;

    assign pc_plus1      = pc_q + ADDR_W'(1);
    assign branch_target = pc_plus1 + ADDR_W'(imm_sext);
    assign jump_target   = ADDR_W'({6'b0, ir[25:0]});
    assign taken         = (iclass == I_BEQ && a_q == b_q) || (iclass == I_BNE && a_q != b_q);

    mips_mc_regfile u_regfile (
        .clock   (clock),
        .reset   (reset),
        .rs_addr (rs),
        .rt_addr (rt),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .we      (rf_we),
        .wr_addr (rf_waddr),
        .wr_data (rf_wdata)
    );

    // Shifts take the value from rt; everything else uses A op (B or immediate).
    always_comb begin
        alu_b = (iclass == I_ALU_R) ? b_q : imm_sext;
        case (alu_op)
            ALU_ADD: alu_result = a_q + alu_b;
            ALU_SUB: alu_result = a_q - alu_b;
            ALU_AND: alu_result = a_q & alu_b;
            ALU_OR:  alu_result = a_q | alu_b;
            ALU_SLT: alu_result = {31'b0, $signed(a_q) < $signed(alu_b)};
            ALU_SLL: alu_result = b_q << shamt;
            ALU_SRL: alu_result = b_q >> shamt;
            default: alu_result = a_q + alu_b;
        endcase
    end

    // jal links in EXEC; ALU results and loads retire in WB.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = alu_out;
        if (state == EXEC && iclass == I_JAL) begin
            rf_we    = 1'b1;
            rf_waddr = 5'd31;
            rf_wdata = 32'(pc_plus1);
        end else if (state == WB) begin
            case (iclass)
                I_ALU_R: begin rf_we = 1'b1; rf_waddr = rd; end
                I_ADDI:  begin rf_we = 1'b1; rf_waddr = rt; end
                I_LW:    begin rf_we = 1'b1; rf_waddr = rt; rf_wdata = mdr; end
                default: rf_we = 1'b0;
            endcase
        end
    end

    // Control FSM. pc_q stays on the executing instruction until the last
    // state of that instruction, so the pc port always names it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= FETCH;
            pc_q    <= RESET_PC;
            ir      <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_out <= '0;
            mdr     <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (mem.mem_ready) begin
                        ir    <= mem.mem_rdata;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    a_q   <= rs_data;
                    b_q   <= rt_data;
                    state <= (iclass == I_ILLEGAL) ? HALT : EXEC;
                end
                EXEC: begin
                    alu_out <= alu_result;
                    case (iclass)
                        I_BEQ, I_BNE: begin pc_q <= taken ? branch_target : pc_plus1; state <= FETCH; end
                        I_J, I_JAL:   begin pc_q <= jump_target;  state <= FETCH; end
                        I_JR:         begin pc_q <= ADDR_W'(a_q); state <= FETCH; end
                        I_ALU_R, I_ADDI: state <= WB;
                        I_LW, I_SW:      state <= MEM;
                        default:         state <= HALT;
                    endcase
                end
                MEM: begin
                    if (mem.mem_ready) begin
                        if (iclass == I_SW) begin
                            pc_q  <= pc_plus1;
                            state <= FETCH;
                        end else begin
                            mdr   <= mem.mem_rdata;
                            state <= WB;
                        end
                    end
                end
                WB: begin
                    pc_q  <= pc_plus1;
                    state <= FETCH;
                end
                HALT:    state <= HALT;
                default: state <= HALT;
            endcase
        end
    end

    // Bus outputs come only from registered state; reset masks them so a
    // request in flight is dropped in the very cycle reset is raised.
    assign mem.mem_req   = !reset && (state == FETCH || state == MEM);
    assign mem.mem_we    = !reset && state == MEM && iclass == I_SW;
    assign mem.mem_addr  = reset ? '0 : ((state == MEM) ? ADDR_W'(alu_out) : pc_q);
    assign mem.mem_wdata = reset ? '0 : b_q;
    assign pc            = reset ? RESET_PC : pc_q;
    assign halted        = !reset && state == HALT;
endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core: self-checking bench for mips_multicycle_core.
// A wait-state memory model answers the unified port; a vector table runs
// short programs and checks a result register, and hand sequences check
// cycle timing, branches, jumps, halt and reset in the middle of a store.
module tb_mips_multicycle_core;
    localparam int ADDR_W = 16;
    localparam logic [5:0] OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR = 6'h08, FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;
    localparam logic [31:0] HALT_WORD = 32'hFC00_0000;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [ADDR_W-1:0] pc_out;
    logic halted;

    mips_multicycle_core_if #(.ADDR_W(ADDR_W)) bus();

    mips_multicycle_core #(.ADDR_W(ADDR_W), .RESET_PC('0)) dut (
        .clock  (clock),
        .reset  (reset),
        .mem    (bus),
        .pc     (pc_out),
        .halted (halted)
    );

    always #5 clock = ~clock;

    typedef struct {
        string             name;
        logic [7:0][31:0]  prog;
        int                waits;
        int                reg_idx;
        logic [31:0]       expect_val;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] mem [256];
    int          cyc = 0, wait_cycles = 0, wait_cnt = 0, write_count = 0;
    int          last_waddr = 0;
    logic [31:0] last_wdata = '0;
    int          fetch_cyc[$];
    int          fetch_addr[$];
    int          compared = 0, mismatched = 0;

    // Memory model: decides ready at each falling edge; the core samples it
    // at the following rising edge. Fetches are logged as reads at the pc.
    always @(negedge clock) begin
        cyc = cyc + 1;
        if (bus.mem_req) begin
            if (wait_cnt < wait_cycles) begin
                bus.mem_ready = 1'b0;
                bus.mem_rdata = 32'hDEAD_BEEF;
                wait_cnt = wait_cnt + 1;
            end else begin
                bus.mem_ready = 1'b1;
                wait_cnt = 0;
                if (bus.mem_we) begin
                    mem[bus.mem_addr[7:0]] = bus.mem_wdata;
                    write_count = write_count + 1;
                    last_waddr = int'(bus.mem_addr);
                    last_wdata = bus.mem_wdata;
                end else begin
                    bus.mem_rdata = mem[bus.mem_addr[7:0]];
                    if (bus.mem_addr == pc_out) begin
                        fetch_cyc.push_back(cyc);
                        fetch_addr.push_back(int'(bus.mem_addr));
                    end
                end
            end
        end else begin
            bus.mem_ready = 1'b0;
            wait_cnt = 0;
        end
    end

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(logic [5:0] op, int tgt);
        return {op, 26'(tgt)};
    endfunction

    function automatic int fetch_cyc_at(int i);
        if (i < fetch_cyc.size()) return fetch_cyc[i];
        return -1;
    endfunction

    function automatic int fetch_addr_at(int i);
        if (i < fetch_addr.size()) return fetch_addr[i];
        return -1;
    endfunction

    task automatic check_output(string name, logic [31:0] actual, logic [31:0] expected);
        compared = compared + 1;
        if (actual !== expected) begin
            mismatched = mismatched + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic add_vec(string name, int waits, int r, logic [31:0] ev,
                           logic [31:0] p0, logic [31:0] p1, logic [31:0] p2, logic [31:0] p3);
        vec_t v;
        v.name = name;
        v.waits = waits;
        v.reg_idx = r;
        v.expect_val = ev;
        v.prog = {HALT_WORD, HALT_WORD, HALT_WORD, HALT_WORD, p3, p2, p1, p0};
        vecs.push_back(v);
    endtask

    // Reset released 2 time units after a rising edge; cycle 1 is the first
    // cycle with reset low.
    task automatic release_reset(int n);
        repeat (n) @(posedge clock);
        #2;
        reset = 1'b0;
        cyc = 0;
        write_count = 0;
        fetch_cyc.delete();
        fetch_addr.delete();
    endtask

    task automatic apply_stimulus(logic [7:0][31:0] prog, int waits, int xaddr, logic [31:0] xword);
        @(posedge clock);
        #2;
        reset = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = HALT_WORD;
        for (int i = 0; i < 8; i++) mem[i] = prog[i];
        if (xaddr >= 0) mem[xaddr] = xword;
        wait_cycles = waits;
        release_reset(2);
    endtask

    task automatic run_until_halt(int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            #1;
            if (halted) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        bit found;
        int req_seen;
        logic [7:0][31:0] p;
        int exp_addr[7];
        int exp_cyc[7];

        add_vec("add",       0, 3, 32'd2,
                enc_i(OP_ADDI,0,1,5), enc_i(OP_ADDI,0,2,-3), enc_r(1,2,3,0,FN_ADD), HALT_WORD);
        add_vec("sub",       0, 3, 32'hFFFF_FFFE,
                enc_i(OP_ADDI,0,1,5), enc_i(OP_ADDI,0,2,7), enc_r(1,2,3,0,FN_SUB), HALT_WORD);
        add_vec("and",       0, 3, 32'd8,
                enc_i(OP_ADDI,0,1,12), enc_i(OP_ADDI,0,2,10), enc_r(1,2,3,0,FN_AND), HALT_WORD);
        add_vec("or",        0, 3, 32'd14,
                enc_i(OP_ADDI,0,1,12), enc_i(OP_ADDI,0,2,10), enc_r(1,2,3,0,FN_OR), HALT_WORD);
        add_vec("slt_neg",   0, 3, 32'd1,
                enc_i(OP_ADDI,0,1,-1), enc_i(OP_ADDI,0,2,1), enc_r(1,2,3,0,FN_SLT), HALT_WORD);
        add_vec("slt_pos",   0, 3, 32'd0,
                enc_i(OP_ADDI,0,1,-1), enc_i(OP_ADDI,0,2,1), enc_r(2,1,3,0,FN_SLT), HALT_WORD);
        add_vec("sll",       0, 3, 32'h30,
                enc_i(OP_ADDI,0,1,3), enc_r(0,1,3,4,FN_SLL), HALT_WORD, HALT_WORD);
        add_vec("srl",       0, 3, 32'h3FFF_FFFC,
                enc_i(OP_ADDI,0,1,-16), enc_r(0,1,3,2,FN_SRL), HALT_WORD, HALT_WORD);
        add_vec("addi_wrap", 0, 3, 32'd0,
                enc_i(OP_ADDI,0,1,-1), enc_i(OP_ADDI,1,3,1), HALT_WORD, HALT_WORD);
        add_vec("r0_write",  0, 0, 32'd0,
                enc_i(OP_ADDI,0,0,7), HALT_WORD, HALT_WORD, HALT_WORD);
        add_vec("bne_fall",  0, 5, 32'd9,
                enc_i(OP_ADDI,0,1,1), enc_i(OP_BNE,1,1,5), enc_i(OP_ADDI,0,5,9), HALT_WORD);
        add_vec("beq_skip",  0, 5, 32'd0,
                enc_i(OP_ADDI,0,1,1), enc_i(OP_BEQ,1,1,1), enc_i(OP_ADDI,0,5,9), enc_i(OP_ADDI,0,6,4));
        add_vec("bne_taken", 0, 5, 32'd0,
                enc_i(OP_ADDI,0,1,1), enc_i(OP_BNE,1,0,1), enc_i(OP_ADDI,0,5,9), HALT_WORD);
        add_vec("j_skip",    0, 5, 32'd0,
                enc_j(OP_J,2), enc_i(OP_ADDI,0,5,9), enc_i(OP_ADDI,0,6,1), HALT_WORD);
        add_vec("sw_lw",     2, 4, 32'd2,
                enc_i(OP_ADDI,0,3,2), enc_i(OP_SW,0,3,4), enc_i(OP_LW,0,4,4), HALT_WORD);

        foreach (vecs[k]) begin
            apply_stimulus(vecs[k].prog, vecs[k].waits, -1, '0);
            run_until_halt(400, ok);
            check_output({vecs[k].name, "_halt"}, 32'(ok), 32'd1);
            check_output(vecs[k].name, dut.u_regfile.regs[vecs[k].reg_idx], vecs[k].expect_val);
        end

        // addi/addi/add with zero-wait memory: 4 cycles each, r3 lands at the
        // end of cycle 12.
        apply_stimulus(vecs[0].prog, 0, -1, '0);
        for (int i = 1; i <= 13; i++) begin
            @(negedge clock);
            #1;
            if (cyc == 12) check_output("r3_before_wb", dut.u_regfile.regs[3], 32'd0);
            if (cyc == 13) check_output("r3_after_12", dut.u_regfile.regs[3], 32'd2);
        end
        for (int i = 0; i < 4; i++) begin
            check_output($sformatf("alu_fetch_addr%0d", i), 32'(fetch_addr_at(i)), 32'(i));
            check_output($sformatf("alu_fetch_cyc%0d", i), 32'(fetch_cyc_at(i)), 32'(1 + 4 * i));
        end

        // sw/lw with two wait cycles on every request: addi 6, sw 8, lw 9.
        apply_stimulus(vecs[14].prog, 2, -1, '0);
        run_until_halt(400, ok);
        check_output("wait_fetch0_cyc", 32'(fetch_cyc_at(0)), 32'd3);
        check_output("sw_cycles", 32'(fetch_cyc_at(2) - fetch_cyc_at(1)), 32'd8);
        check_output("lw_cycles", 32'(fetch_cyc_at(3) - fetch_cyc_at(2)), 32'd9);
        check_output("sw_count", 32'(write_count), 32'd1);
        check_output("sw_addr", 32'(last_waddr), 32'd4);
        check_output("sw_data", last_wdata, 32'd2);

        // beq r1,r1,-1 at address 8 spins on itself every 3 cycles.
        p = {NOP, NOP, NOP, NOP, NOP, NOP, NOP, enc_i(OP_ADDI,0,1,1)};
        apply_stimulus(p, 0, 8, enc_i(OP_BEQ,1,1,-1));
        repeat (60) @(negedge clock);
        #1;
        check_output("beq_loop_first", 32'(fetch_cyc_at(8)), 32'd33);
        for (int i = 8; i < 11; i++) begin
            check_output($sformatf("beq_loop_addr%0d", i), 32'(fetch_addr_at(i)), 32'd8);
            check_output($sformatf("beq_loop_gap%0d", i),
                         32'(fetch_cyc_at(i + 1) - fetch_cyc_at(i)), 32'd3);
        end

        // jal 0x20 at address 3, then jr r31 back to 4.
        p = {HALT_WORD, HALT_WORD, HALT_WORD, enc_i(OP_ADDI,0,7,3),
             enc_j(OP_JAL,32'h20), NOP, NOP, enc_i(OP_ADDI,0,1,1)};
        apply_stimulus(p, 0, 32'h20, enc_r(31,0,0,0,FN_JR));
        run_until_halt(400, ok);
        exp_addr = '{0, 1, 2, 3, 32'h20, 4, 5};
        exp_cyc  = '{1, 5, 9, 13, 16, 19, 23};
        for (int i = 0; i < 7; i++) begin
            check_output($sformatf("jal_fetch_addr%0d", i), 32'(fetch_addr_at(i)), 32'(exp_addr[i]));
            check_output($sformatf("jal_fetch_cyc%0d", i), 32'(fetch_cyc_at(i)), 32'(exp_cyc[i]));
        end
        check_output("jal_r31", dut.u_regfile.regs[31], 32'd4);
        check_output("jr_return_r7", dut.u_regfile.regs[7], 32'd3);

        // Illegal opcode and illegal R-type funct: halted two cycles after the
        // fetch is accepted, and no further requests.
        for (int t = 0; t < 2; t++) begin
            p = {HALT_WORD, HALT_WORD, HALT_WORD, HALT_WORD, HALT_WORD, HALT_WORD, HALT_WORD,
                 (t == 0) ? HALT_WORD : enc_r(1,2,3,0,6'h3F)};
            apply_stimulus(p, 0, -1, '0);
            repeat (2) @(negedge clock);
            #1;
            check_output($sformatf("halt%0d_cyc2", t), 32'(halted), 32'd0);
            @(negedge clock);
            #1;
            check_output($sformatf("halt%0d_cyc3", t), 32'(halted), 32'd1);
            req_seen = 0;
            repeat (5) begin
                @(negedge clock);
                #1;
                if (bus.mem_req) req_seen = req_seen + 1;
            end
            check_output($sformatf("halt%0d_no_req", t), 32'(req_seen), 32'd0);
            check_output($sformatf("halt%0d_sticky", t), 32'(halted), 32'd1);
        end
        p = {HALT_WORD, HALT_WORD, HALT_WORD, HALT_WORD, HALT_WORD, HALT_WORD, HALT_WORD,
             enc_i(OP_ADDI,0,1,1)};
        apply_stimulus(p, 0, -1, '0);
        @(negedge clock);
        #1;
        check_output("after_halt_unhalted", 32'(halted), 32'd0);
        check_output("after_halt_req", 32'(bus.mem_req), 32'd1);
        check_output("after_halt_addr", 32'(bus.mem_addr), 32'd0);

        // Reset raised while a store waits in MEM: no write, outputs at reset
        // values, then a clean restart at address 0.
        p = {HALT_WORD, HALT_WORD, HALT_WORD, HALT_WORD, HALT_WORD, HALT_WORD,
             enc_i(OP_SW,0,3,4), enc_i(OP_ADDI,0,3,2)};
        apply_stimulus(p, 3, -1, '0);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            #1;
            if (bus.mem_req && bus.mem_we) begin
                found = 1'b1;
                break;
            end
        end
        check_output("sw_mem_reached", 32'(found), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        #1;
        check_output("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check_output("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check_output("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check_output("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check_output("rst_pc", 32'(pc_out), 32'd0);
        check_output("rst_halted", 32'(halted), 32'd0);
        check_output("rst_r3_cleared", dut.u_regfile.regs[3], 32'd0);
        check_output("rst_no_write", 32'(write_count), 32'd0);
        check_output("rst_mem4_untouched", mem[4], HALT_WORD);
        mem[0] = enc_i(OP_ADDI,0,0,7);
        mem[1] = HALT_WORD;
        wait_cycles = 0;
        release_reset(1);
        run_until_halt(100, ok);
        check_output("restart_halt", 32'(ok), 32'd1);
        check_output("restart_addr", 32'(fetch_addr_at(0)), 32'd0);
        check_output("restart_r0", dut.u_regfile.regs[0], 32'd0);
        check_output("restart_no_write", 32'(write_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
